memory_stage: RTL

Fourth stage of the SRV1 pipeline. It consumes the execute-stage output buffer (control, instruction, ALU result, incremented PC, RS2 data, branch result) and performs loads and stores over a single-outstanding request/acknowledge data bus. It also drives the branch/jump redirect, exposes the destination register for hazard and forwarding logic, and registers the result for the writeback stage. While a bus access is outstanding, `stall` freezes every upstream stage.

---
 rtl/memory_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// SRV1 pipeline memory stage: loads/stores over a single-outstanding req/ack bus,
// branch redirect, hazard/forwarding taps and the registered writeback result.
module memory_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ctr_in,
    input  logic [31:0] inst_in,
    input  logic [31:0] alu_in,
    input  logic [29:0] inc_pc_in,
    input  logic [31:0] rs2_data_in,
    input  logic        branch_result_in,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    output logic        bus_we,
    output logic        bus_req,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic        redirect_valid,
    output logic [29:0] redirect_pc,
    output logic [4:0]  mem_rd,
    output logic        mem_writes_rd,
    output logic        mem_load_pending,
    output logic [31:0] mem_fwd_data,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_err
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned PCW  = 30;

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;

    logic [2:0]      fn3;
    logic [1:0]      off;
    logic            mem_op;
    logic            is_store;
    logic            aligned;
    logic [XLEN-1:0] st_wdata;
    logic [3:0]      st_be;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;
    logic            unused_ok;

    assign fn3      = inst_in[14:12];
    assign off      = alu_in[1:0];
    assign mem_op   = ctr_in[0] | ctr_in[1];
    assign is_store = ctr_in[1];

    assign redirect_valid   = branch_result_in;
    assign redirect_pc      = alu_in[XLEN-1:2];
    assign mem_rd           = inst_in[11:7];
    assign mem_writes_rd    = ctr_in[2] && (mem_rd != 5'd0);
    assign mem_load_pending = ctr_in[0];
    assign mem_fwd_data     = (ctr_in[4:3] == 2'b10) ? {inc_pc_in, 2'b00} : alu_in;

    // Instruction fields this stage never looks at
    assign unused_ok = ^{inst_in[31:15], inst_in[6:0]};

    // Access-size alignment; load fn3 110/111 has no meaning
    always_comb begin
        aligned = 1'b0;
        case (fn3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~off[0];
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b0;
        endcase
        if (!is_store && fn3[2] && fn3[1])
            aligned = 1'b0;
    end

    // Lane-replicated store data and byte enables
    always_comb begin
        st_wdata = rs2_data_in;
        st_be    = 4'hF;
        case (fn3[1:0])
            2'b00: begin
                st_wdata = {4{rs2_data_in[7:0]}};
                st_be    = 4'b0001 << off;
            end
            2'b01: begin
                st_wdata = {2{rs2_data_in[15:0]}};
                st_be    = 4'b0011 << off;
            end
            default: ;
        endcase
    end

    // Lane select and extension of returned load data
    always_comb begin
        ld_byte = 8'(bus_rdata >> {off, 3'b000});
        ld_half = 16'(bus_rdata >> {off[1], 4'b0000});
        case (fn3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    // Gated by reset so an abandoned access releases the pipeline immediately
    assign stall = !rst && (((state == IDLE) && mem_op && aligned) ||
                            ((state == BUSY) && !bus_ack));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_be       <= '0;
            bus_we       <= 1'b0;
            bus_req      <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        wb_valid <= 1'b0;
                        if (aligned) begin
                            bus_addr  <= PCW'(alu_in[XLEN-1:2]);
                            bus_wdata <= st_wdata;
                            bus_be    <= is_store ? st_be : 4'hF;
                            bus_we    <= is_store;
                            bus_req   <= 1'b1;
                            state     <= BUSY;
                        end else begin
                            misalign_err <= 1'b1;
                        end
                    end else begin
                        wb_valid <= mem_writes_rd;
                        wb_rd    <= mem_rd;
                        wb_data  <= mem_fwd_data;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= IDLE;
                        if (is_store) begin
                            wb_valid <= 1'b0;
                        end else begin
                            wb_valid <= mem_writes_rd;
                            wb_rd    <= mem_rd;
                            wb_data  <= ld_data;
                        end
                    end else begin
                        wb_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
